// File: rtl/nes_if.sv
// Controller-port pins and parallel result bus between the NES reader and its neighbours.
// master = the reader, slave = controller pins plus display path.
interface nes_if;
   logic       nes_data;
   logic       nes_latch;
   logic       nes_clk;
   logic [7:0] buttons;
   logic       buttons_valid;
   logic [3:0] btn_code;

   modport master (
      input  nes_data,
      output nes_latch, nes_clk, buttons, buttons_valid, btn_code
   );

   modport slave (
      output nes_data,
      input  nes_latch, nes_clk, buttons, buttons_valid, btn_code
   );
endinterface

// File: rtl/nes_reader.sv
// Polls an NES controller (latch/clock/data) and publishes the eight buttons plus a
// priority-encoded 4-bit display code, updated once per frame with a one-cycle valid pulse.
module nes_reader #(
   parameter int HALF_CYCLES = 300,
   parameter int POLL_TICKS  = 2778
) (
   input  logic  clk,
   input  logic  rst_n,
   nes_if.master bus
);
   localparam int TW = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
   localparam int PW = (POLL_TICKS > 1) ? $clog2(POLL_TICKS) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(HALF_CYCLES - 1);
   localparam logic [PW-1:0] POLL_LAST = PW'(POLL_TICKS - 1);

   typedef enum logic [1:0] {IDLE, LATCH, READ_LO, READ_HI} state_e;

   state_e        state_q, state_d;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic [PW-1:0] poll_cnt_q, poll_cnt_d;
   logic          latch_cnt_q, latch_cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    buttons_q, buttons_d;
   logic [3:0]    btn_code_q, btn_code_d;
   logic          valid_q, valid_d;
   logic          sync1_q, sync2_q;
   logic          tick, commit;
   logic [7:0]    frame;

   function automatic logic [3:0] encode(input logic [7:0] b);
      encode = 4'hF;
      for (int i = 7; i >= 0; i--) begin
         if (b[i]) encode = 4'(i);
      end
   endfunction

   assign tick   = (tick_cnt_q == TICK_LAST);
   assign commit = tick && (state_q == READ_LO) && (bit_idx_q == 3'd7);

   // State register.
   // NOTE: synchronous reset is tested inside the clocked block; all flops use <=.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state and sequencing counters; everything advances only on a tick.
   // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
   always_comb begin
      state_d     = state_q;
      poll_cnt_d  = poll_cnt_q;
      latch_cnt_d = latch_cnt_q;
      bit_idx_d   = bit_idx_q;
      if (tick) begin
         unique case (state_q)
            IDLE: begin
               if (poll_cnt_q == POLL_LAST) begin
                  poll_cnt_d = '0;
                  state_d    = LATCH;
               end else begin
                  poll_cnt_d = poll_cnt_q + 1'b1;
               end
            end
            LATCH: begin
               latch_cnt_d = ~latch_cnt_q;
               if (latch_cnt_q) begin
                  bit_idx_d = '0;
                  state_d   = READ_LO;
               end
            end
            READ_LO: begin
               if (bit_idx_q == 3'd7) begin
                  bit_idx_d = '0;
                  state_d   = IDLE;
               end else begin
                  state_d = READ_HI;
               end
            end
            READ_HI: begin
               bit_idx_d = bit_idx_q + 3'd1;
               state_d   = READ_LO;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Pin outputs decode directly from the state.
   always_comb begin
      bus.nes_latch = (state_q == LATCH);
      bus.nes_clk   = (state_q == READ_HI);
   end

   // Datapath: free-running tick, bit capture and commit of the finished frame.
   always_comb begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
      shift_d    = shift_q;
      buttons_d  = buttons_q;
      btn_code_d = btn_code_q;
      frame      = shift_q;
      frame[bit_idx_q] = ~sync2_q;
      if (tick && (state_q == READ_LO)) shift_d = frame;
      if (commit) begin
         buttons_d  = frame;
         btn_code_d = encode(frame);
      end
      valid_d = commit;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tick_cnt_q  <= '0;
         poll_cnt_q  <= '0;
         latch_cnt_q <= 1'b0;
         bit_idx_q   <= '0;
         shift_q     <= 8'h00;
         buttons_q   <= 8'h00;
         btn_code_q  <= 4'hF;
         valid_q     <= 1'b0;
         // NOTE: the synchronizer resets to 1 (line released) so reset never reads as a press.
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
      end else begin
         tick_cnt_q  <= tick_cnt_d;
         poll_cnt_q  <= poll_cnt_d;
         latch_cnt_q <= latch_cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         buttons_q   <= buttons_d;
         btn_code_q  <= btn_code_d;
         valid_q     <= valid_d;
         sync1_q     <= bus.nes_data;
         sync2_q     <= sync1_q;
      end
   end

   assign bus.buttons       = buttons_q;
   assign bus.btn_code      = btn_code_q;
   assign bus.buttons_valid = valid_q;
endmodule

// File: tb/tb_nes_reader.sv
// Scoreboard bench for nes_reader: a behavioural controller pushes the latched pattern,
// a monitor pops and compares on every buttons_valid pulse.
module tb_nes_reader;
   localparam int HC     = 4;
   localparam int PT     = 3;
   localparam int PERIOD = (17 + PT) * HC;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] pad   = 8'h00;

   nes_if bus();

   nes_reader #(.HALF_CYCLES(HC), .POLL_TICKS(PT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          pass_cnt  = 0;
   int          total_cnt = 0;
   logic [11:0] sb[$];
   logic [11:0] exp_item;
   logic [7:0]  last_commit = 8'h00;
   int          gcyc        = 0;
   int          last_valid  = -1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
   endtask

   // Lowest set bit index via isolating the lowest one and counting the ones below it.
   function automatic logic [3:0] ref_code(input logic [7:0] x);
      logic [7:0] low;
      low = x & (~x + 8'd1);
      return (x == 8'h00) ? 4'hF : 4'($countones(low - 8'd1));
   endfunction

   // Controller model: parallel load while latched, shift on each nes_clk rise.
   int   idx        = 0;
   logic noise      = 1'b1;
   logic prev_latch = 1'b0;
   logic prev_nclk  = 1'b0;

   always @(negedge clk) begin
      if (bus.buttons_valid) noise = 1'b1;
      if (bus.nes_latch) begin
         idx = 0;
         if (!prev_latch) begin
            noise = 1'b0;
            check("hold_between_frames", {bus.buttons, bus.btn_code},
                  {last_commit, ref_code(last_commit)});
            sb.push_back({pad, ref_code(pad)});
         end
      end else if (bus.nes_clk && !prev_nclk) begin
         idx++;
      end
      prev_latch = bus.nes_latch;
      prev_nclk  = bus.nes_clk;
      bus.nes_data = noise ? 1'($urandom) : ((idx < 8) ? ~pad[idx] : 1'b1);
   end

   // Monitor: reset bookkeeping on the active edge, comparisons on the opposite edge.
   always @(clk) begin
      if (clk) begin
         gcyc++;
         if (!rst_n) begin
            sb.delete();
            last_valid  = -1;
            last_commit = 8'h00;
         end
      end else if (bus.buttons_valid) begin
         check("sb_nonempty", sb.size() > 0, 1'b1);
         if (sb.size() > 0) begin
            exp_item = sb.pop_front();
            check("buttons", bus.buttons, exp_item[11:4]);
            check("btn_code", bus.btn_code, exp_item[3:0]);
            last_commit = exp_item[11:4];
         end
         if (last_valid >= 0) check("valid_spacing", gcyc - last_valid, PERIOD);
         last_valid = gcyc;
      end
   end

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.buttons_valid && n < 400);
      check("valid_seen", bus.buttons_valid, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, want finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      int         n;
      logic [7:0] pats[$];

      rst_n = 1'b0;
      repeat (10) begin
         @(negedge clk);
         check("reset_outs",
               {bus.nes_latch, bus.nes_clk, bus.buttons_valid, bus.buttons, bus.btn_code},
               {3'b000, 8'h00, 4'hF});
      end

      // First frame (A + Start) with exact pin timing from release.
      pad = 8'h09;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 100; c++) begin
         if (c > 0) @(negedge clk);
         if (c == 85) pad = 8'h20;
         check("latch_timing", bus.nes_latch, (c >= 12 && c <= 19) || c >= 92);
         check("nclk_timing", bus.nes_clk, c >= 24 && c <= 75 && ((c - 24) % 8) < 4);
         check("valid_timing", bus.buttons_valid, c == 80);
      end

      // Back-to-back frames: Down only, none, all, random, alternating, then A + Start.
      pats = '{8'h00, 8'hFF};
      repeat (6) pats.push_back(8'($urandom));
      pats.push_back(8'hAA);
      pats.push_back(8'h55);
      pats.push_back(8'hAA);
      pats.push_back(8'h55);
      pats.push_back(8'h09);
      foreach (pats[i]) begin
         wait_valid(n);
         pad = pats[i];
      end
      wait_valid(n);

      // Abort a frame during READ_HI of bit 3.
      pad = 8'hAA;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.nes_latch && n < 200);
      check("latch_seen", bus.nes_latch, 1'b1);
      repeat (37) @(negedge clk);
      check("in_read_hi_bit3", bus.nes_clk, 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_outs",
            {bus.nes_latch, bus.nes_clk, bus.buttons_valid, bus.buttons, bus.btn_code},
            {3'b000, 8'h00, 4'hF});
      rst_n = 1'b1;
      for (int c = 0; c <= 12; c++) begin
         if (c > 0) @(negedge clk);
         check("relatch_timing", bus.nes_latch, c == 12);
         if (c < 12) check("abort_hold", {bus.buttons_valid, bus.buttons, bus.btn_code},
                           {1'b0, 8'h00, 4'hF});
      end
      wait_valid(n);
      check("abort_valid_latency", n, 68);

      repeat (5) @(negedge clk);
      check("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/nes_reader.md
# nes_reader

Polls a standard NES controller over its latch/clock/data serial interface and presents the eight button states as a parallel register. It also produces a 4-bit button code that feeds the 7-segment decoder directly: 0–7 identifies the lowest-index pressed button, and 4'hF blanks the display when nothing is pressed. The block sits between the controller port pins and the display path, and runs from the single system clock.

## Interface
- HALF_CYCLES, default 300: system clocks per half-period "tick" (6 µs at 50 MHz); must be ≥2.
- POLL_TICKS, default 2778: ticks spent idle between frames (~60 Hz poll at default); must be ≥1.
- clk  input  1  system clock; all logic rises on posedge clk.
- rst_n  input  1  reset, synchronous, active-low.
- nes_data  input  1  controller serial data, asynchronous, active-low (0 = pressed).
- nes_latch  output  1  controller latch pulse, active-high.
- nes_clk  output  1  controller shift clock; idle low.
- buttons  output  8  registered button state, 1 = pressed; bit0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right.
- buttons_valid  output  1  one-cycle pulse when buttons/btn_code update.
- btn_code  output  4  lowest set index of buttons (0–7), or 4'hF if buttons == 0.

## Operation
- Tick generator: tick_cnt, free-running, is 0 in the first cycle after reset release and counts 0..HALF_CYCLES-1. tick = (tick_cnt == HALF_CYCLES-1). It is never realigned to the FSM.
- nes_data passes through a 2-flop synchronizer; all samples use the synchronized value.
- FSM (all transitions on tick only):
  - IDLE: nes_latch=0, nes_clk=0. On tick: if poll_cnt == POLL_TICKS-1, clear poll_cnt and go to LATCH; otherwise increment poll_cnt.
  - LATCH: nes_latch=1 for 2 ticks (internal 1-bit counter), then go to READ_LO with bit_idx=0.
  - READ_LO: nes_clk=0. On tick: shift[bit_idx] <= ~data_sync. If bit_idx==7, go to IDLE and commit; otherwise go to READ_HI.
  - READ_HI: nes_clk=1. On tick: bit_idx++, go to READ_LO.
- Commit (same edge as the bit-7 sample): buttons <= final shift value including bit 7; btn_code <= priority encode; buttons_valid=1 for exactly that one following cycle.
- Encoder priority: bit0 highest. Codes 8–14 are never produced.
- Reset values: nes_latch 0, nes_clk 0, buttons 8'h00, buttons_valid 0, btn_code 4'hF, state IDLE, poll_cnt 0, bit_idx 0, tick_cnt 0, synchronizer flops 1.
- Reset mid-frame (any state): abort immediately to the reset values. buttons does not retain the old frame, and no partial commit occurs.
- Counter widths are $clog2 of the respective limits. No wrap hazards: each counter clears at its limit.

## Timing
- Frame: 2 latch + 8 low + 7 high = 17 ticks, plus POLL_TICKS idle ticks. Period = (17+POLL_TICKS)·HALF_CYCLES cycles.
- First latch rises POLL_TICKS·HALF_CYCLES cycles after the first cycle with rst_n high (cycle 0).
- Bit i is sampled on the last cycle of its READ_LO phase, (2+2i+1)·HALF_CYCLES-1 cycles after latch rise. The data seen is nes_data as it was 2 cycles earlier.
- nes_data must be stable ≥3 cycles before each sample point.
- buttons_valid rises in the cycle after the bit-7 sample; buttons/btn_code change in that same cycle and hold until the next commit.

## Test plan
(All with HALF_CYCLES=4, POLL_TICKS=3, so the frame period is 80 cycles.)
- Reset: hold rst_n low 10 cycles with nes_data toggling -> nes_latch=0, nes_clk=0, buttons=00, btn_code=F, buttons_valid=0 throughout.
- Frame timing: release reset at cycle 0 -> nes_latch high cycles 12–19; nes_clk high 24–27, 32–35, …, 72–75 (7 pulses); buttons_valid high only in cycle 80; next latch rises at cycle 92.
- Data: controller model drives A and Start pressed -> buttons=8'h09, btn_code=0. Only Down -> 8'h20, code 5. None -> 8'h00, code F. All -> 8'hFF, code 0.
- Hold between frames: change nes_data during IDLE -> buttons/btn_code unchanged until the next buttons_valid.
- Reset mid-frame: assert rst_n low for 1 cycle during READ_HI of bit 3, after a prior frame committed 8'h09 -> all outputs return to reset values the next cycle; latch rises again 12 cycles after release; no buttons_valid pulse for the aborted frame.
- Back-to-back frames with alternating patterns 8'hAA/8'h55 -> each commit exact, btn_code 1 then 0, valid pulses exactly 80 cycles apart.
